// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and memory (slave).
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: one req/ack bus transfer per memory instruction.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Enable_In,
  input  logic              rw_In,
  input  logic [1:0]        Size_In,
  input  logic [ADDR_W-1:0] Addr_In,
  input  logic [31:0]       WData_In,
  output logic              Stall_Out,
  output logic [31:0]       RData_Out,
  output logic              RValid_Out,
  output logic              Misalign_Out,
  output logic              Err_Out,
  mem_access_ctrl_if.master bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_access_ctrl: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;
  logic              timeout_c;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`endif

  logic              aligned_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c;
  logic [31:0]       extract_c;

  // Request-side lane formatting from the incoming instruction
  always_comb begin
    unique case (Size_In)
      2'b00: begin
        aligned_c = 1'b1;
        be_c      = 4'b0001 << Addr_In[1:0];
        wdata_c   = {4{WData_In[7:0]}};
      end
      2'b01: begin
        aligned_c = ~Addr_In[0];
        be_c      = Addr_In[1] ? 4'b1100 : 4'b0011;
        wdata_c   = {2{WData_In[15:0]}};
      end
      default: begin
        aligned_c = (Addr_In[1:0] == 2'b00);
        be_c      = 4'b1111;
        wdata_c   = WData_In;
      end
    endcase
  end

  // Response-side lane extraction, zero-extended
  always_comb begin
    shifted_c = bus.mem_rdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   extract_c = {24'd0, shifted_c[7:0]};
      2'b01:   extract_c = {16'd0, shifted_c[15:0]};
      default: extract_c = bus.mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  assign timeout_c = (cnt_q == 8'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    err_d      = 1'b0;
    Stall_Out  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Enable_In && aligned_c) begin
          Stall_Out = 1'b1;
          state_d   = REQ;
          req_d     = 1'b1;
          we_d      = rw_In;
          be_d      = be_c;
          addr_d    = {Addr_In[ADDR_W-1:2], 2'b00};
          wdata_d   = wdata_c;
          size_d    = Size_In;
          off_d     = Addr_In[1:0];
`ifdef MEM_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end else if (Enable_In) begin
          misalign_d = 1'b1;
        end
      end
      REQ: begin
        Stall_Out = 1'b1;
        // An ack in the final allowed cycle beats the timeout
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = extract_c;
            rvalid_d = 1'b1;
          end
        end else if (timeout_c) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign RData_Out     = rdata_q;
  assign RValid_Out    = rvalid_q;
  assign Misalign_Out  = misalign_q;
  assign Err_Out       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl against a lane-arithmetic reference model.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        CLK;
  logic        CLR;
  logic        Enable_In;
  logic        rw_In;
  logic [1:0]  Size_In;
  logic [31:0] Addr_In;
  logic [31:0] WData_In;
  logic        Stall_Out;
  logic [31:0] RData_Out;
  logic        RValid_Out;
  logic        Misalign_Out;
  logic        Err_Out;

  int ntotal = 0;
  int npass  = 0;
  logic [31:0] exp_rdata = 32'd0;

  mem_access_ctrl_if #(.ADDR_W(32)) bus_if ();

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .Enable_In    (Enable_In),
    .rw_In        (rw_In),
    .Size_In      (Size_In),
    .Addr_In      (Addr_In),
    .WData_In     (WData_In),
    .Stall_Out    (Stall_Out),
    .RData_Out    (RData_Out),
    .RValid_Out   (RValid_Out),
    .Misalign_Out (Misalign_Out),
    .Err_Out      (Err_Out),
    .bus          (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One instruction from presentation to the idle cycle after completion.
  // d = number of REQ cycles without ack before the ack cycle.
  task automatic run_txn(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int d);
    int          nb, off, ncyc;
    bit          tout;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, mask;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) begin
      ebe[i]         = (i >= off) && (i < off + nb);
      ewd[8*i +: 8]  = wd[8*(i % nb) +: 8];
    end
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    erd  = (rd >> (8*off)) & mask;
`ifdef MEM_TIMEOUT_EN
    tout = (d >= int'(TO));
`else
    tout = 1'b0;
`endif
    ncyc = tout ? int'(TO) : d + 1;

    @(negedge CLK);
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = $urandom;
    Enable_In = 1'b1;
    rw_In     = rw;
    Size_In   = sz;
    Addr_In   = a;
    WData_In  = wd;
    #1;
    if ((a % nb) != 0) begin
      chk("stall_misaligned", Stall_Out, 1'b0);
      @(negedge CLK);
      chk("misalign_pulse", Misalign_Out, 1'b1);
      chk("req_misaligned", bus_if.mem_req, 1'b0);
      chk("rvalid_misaligned", RValid_Out, 1'b0);
      Enable_In = 1'b0;
      @(negedge CLK);
      chk("misalign_end", Misalign_Out, 1'b0);
      chk("req_after_misalign", bus_if.mem_req, 1'b0);
      return;
    end
    chk("stall_accept", Stall_Out, 1'b1);

    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      chk("req_high", bus_if.mem_req, 1'b1);
      chk("stall_req", Stall_Out, 1'b1);
      chk("rvalid_in_req", RValid_Out, 1'b0);
      chk("err_in_req", Err_Out, 1'b0);
      if (c == 0) begin
        chk("bus_we", bus_if.mem_we, rw);
        chk("bus_be", 32'(bus_if.mem_be), 32'(ebe));
        chk("bus_addr", bus_if.mem_addr, {a[31:2], 2'b00});
        chk("bus_wdata", bus_if.mem_wdata, ewd);
      end
      if (!tout && c == d) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = rd;
      end
    end

    @(negedge CLK);
    if (!rw && !tout) exp_rdata = erd;
    chk("req_done", bus_if.mem_req, 1'b0);
    chk("stall_done", Stall_Out, 1'b0);
    chk("rvalid_done", RValid_Out, !rw && !tout);
    chk("err_done", Err_Out, tout);
    chk("rdata_done", RData_Out, exp_rdata);
    // Ack held into DONE must be ignored; Enable still high here too
    bus_if.mem_rdata = $urandom;

    @(negedge CLK);
    chk("req_idle", bus_if.mem_req, 1'b0);
    chk("rvalid_idle", RValid_Out, 1'b0);
    chk("err_idle", Err_Out, 1'b0);
    chk("rdata_idle", RData_Out, exp_rdata);
    Enable_In      = 1'b0;
    bus_if.mem_ack = 1'b1;
    #1;
    chk("stall_idle", Stall_Out, 1'b0);
  endtask

  initial begin
    CLR = 1'b1;
    Enable_In = 1'b0;
    rw_In = 1'b0;
    Size_In = 2'd0;
    Addr_In = 32'd0;
    WData_In = 32'd0;
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = 32'd0;
    #1;
    chk("rst_req", bus_if.mem_req, 1'b0);
    chk("rst_we", bus_if.mem_we, 1'b0);
    chk("rst_be", 32'(bus_if.mem_be), 32'd0);
    chk("rst_addr", bus_if.mem_addr, 32'd0);
    chk("rst_wdata", bus_if.mem_wdata, 32'd0);
    chk("rst_rdata", RData_Out, 32'd0);
    chk("rst_rvalid", RValid_Out, 1'b0);
    chk("rst_misalign", Misalign_Out, 1'b0);
    chk("rst_err", Err_Out, 1'b0);
    chk("rst_stall", Stall_Out, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;

    run_txn(1'b0, 2'b10, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'd0, 2);
    run_txn(1'b0, 2'b01, 32'h0000_0102, 32'd0, 32'h8001_1234, 1);
    run_txn(1'b0, 2'b10, 32'h0000_0101, 32'd0, 32'd0, 0);
    run_txn(1'b0, 2'b11, 32'h0000_0104, 32'd0, 32'h1357_9BDF, 0);
    run_txn(1'b1, 2'b01, 32'h0000_0200, 32'h1234_ABCD, 32'd0, 0);

    // Reset in the middle of an outstanding read, then a stray ack
    @(negedge CLK);
    bus_if.mem_ack = 1'b0;
    Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b10; Addr_In = 32'h0000_0400;
    @(negedge CLK);
    chk("clr_req_before", bus_if.mem_req, 1'b1);
    CLR = 1'b1;
    Enable_In = 1'b0;
    #1;
    exp_rdata = 32'd0;
    chk("clr_req_now", bus_if.mem_req, 1'b0);
    chk("clr_stall", Stall_Out, 1'b0);
    chk("clr_be", 32'(bus_if.mem_be), 32'd0);
    chk("clr_addr", bus_if.mem_addr, 32'd0);
    chk("clr_rdata", RData_Out, 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    chk("late_ack_rvalid", RValid_Out, 1'b0);
    chk("late_ack_req", bus_if.mem_req, 1'b0);
    chk("late_ack_rdata", RData_Out, 32'd0);
    bus_if.mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, 2'b10, 32'h0000_0300, 32'd0, 32'h1111_2222, 1000);
    run_txn(1'b0, 2'b10, 32'h0000_0304, 32'd0, 32'h3333_4444, int'(TO) - 1);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
              $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    @(negedge CLK);
    bus_if.mem_ack = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
